// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, issues imem requests, fills IF/ID; trap vectors fixed.
// Latency: id_valid the edge after imem_valid; stall holds IF/ID, one-entry skid absorbs a word, fetch pauses.
module fetch_stage #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] ILLOP_VEC = 32'h8000_0004,
    parameter logic [ADDR_W-1:0] XADR_VEC  = 32'h8000_0008
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-2:0] imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              exc,
    input  logic              irq,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic              trap_valid,
    output logic [ADDR_W-1:0] trap_epc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              skid_valid;
    logic [31:0]       skid_instr;
    logic [ADDR_W-1:0] skid_pc;

    logic              take_redir;
    logic              take_exc;
    logic              take_irq;
    logic              flush;
    logic              id_free;
    logic              resp;
    logic [ADDR_W-1:0] redir_tgt;

    // Supervisor bit is sticky across sequential fetch; only the low bits wrap.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] p);
        pc_inc = {p[ADDR_W-1], p[ADDR_W-2:0] + (ADDR_W-1)'(4)};
    endfunction

    always_comb begin
        take_redir = redirect_valid;
        take_exc   = !redirect_valid && exc && id_valid;
        take_irq   = !redirect_valid && !take_exc && irq && id_valid && !stall && !id_pc[ADDR_W-1];
        flush      = take_redir || take_exc || take_irq;
        id_free    = !id_valid || !stall;
        resp       = (state == S_WAIT) && imem_valid;
        // A user-mode jump cannot set the supervisor bit.
        redir_tgt  = {redirect_pc[ADDR_W-1] & pc[ADDR_W-1], redirect_pc[ADDR_W-2:0]};
        imem_req   = !flush && !skid_valid && ((state == S_RUN) || (resp && id_free));
        imem_addr  = pc[ADDR_W-2:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            pc     <= RESET_VEC;
            req_pc <= '0;
        end else if (flush) begin
            if (take_redir)    pc <= redir_tgt;
            else if (take_exc) pc <= XADR_VEC;
            else               pc <= ILLOP_VEC;
            // An outstanding request whose response is not here yet must be swallowed.
            if (((state == S_WAIT) || (state == S_DROP)) && !imem_valid)
                state <= S_DROP;
            else
                state <= S_RUN;
        end else begin
            if (imem_req) begin
                req_pc <= pc;
                pc     <= pc_inc(pc);
            end
            case (state)
                S_IDLE:  state <= S_RUN;
                S_RUN:   if (imem_req) state <= S_WAIT;
                S_WAIT:  if (imem_valid) state <= imem_req ? S_WAIT : S_RUN;
                default: if (imem_valid) state <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid   <= 1'b0;
            id_instr   <= '0;
            id_pc      <= '0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            id_valid   <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid && !stall) begin
            id_valid   <= 1'b1;
            id_instr   <= skid_instr;
            id_pc      <= skid_pc;
            skid_valid <= 1'b0;
        end else if (resp && id_free) begin
            id_valid   <= 1'b1;
            id_instr   <= imem_rdata;
            id_pc      <= req_pc;
        end else if (resp) begin
            skid_valid <= 1'b1;
            skid_instr <= imem_rdata;
            skid_pc    <= req_pc;
        end else if (!stall) begin
            id_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trap_valid <= 1'b0;
            trap_epc   <= '0;
        end else begin
            trap_valid <= take_exc || take_irq;
            // Exceptions resume after the bad opcode; interrupts re-execute it.
            if (take_exc)      trap_epc <= pc_inc(id_pc);
            else if (take_irq) trap_epc <= id_pc;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory plus an architectural instruction-stream model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [30:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        exc = 1'b0;
    logic        irq = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        trap_valid;
    logic [31:0] trap_epc;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc            (exc),
        .irq            (irq),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .trap_valid     (trap_valid),
        .trap_epc       (trap_epc)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [30:0] a);
        return ({1'b0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] p);
        return {p[31], p[30:0] + 31'd4};
    endfunction

    // memory: one slot, response after lat_min..lat_max cycles
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [30:0] mem_addr = '0;
    int          lat_min  = 1;
    int          lat_max  = 1;

    // architectural model: next instruction owed to decode, and current privilege
    logic [31:0] exp_pc  = RESET_VEC;
    bit          mode    = 1'b1;
    bit          exp_tv  = 1'b0;
    logic [31:0] exp_epc = '0;

    bit          s_req;
    logic [30:0] s_addr;
    bit          s_idv;
    logic [31:0] s_idpc;
    bit          s_tv;
    logic [31:0] s_epc;
    int          delivered = 0;

    task automatic tick(input bit stl, input bit rv, input logic [31:0] rpc, input bit ex, input bit iq);
        bit          f_exc;
        bit          f_irq;
        logic [31:0] tgt;
        imem_valid = 1'b0;
        imem_rdata = '0;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = word_at(mem_addr);
            end else begin
                mem_cnt--;
            end
        end
        stall = stl; redirect_valid = rv; redirect_pc = rpc; exc = ex; irq = iq;
        #2;
        s_req = imem_req; s_addr = imem_addr; s_idv = id_valid; s_idpc = id_pc;
        s_tv = trap_valid; s_epc = trap_epc;

        check("trap_valid", 32'(trap_valid), 32'(exp_tv));
        if (exp_tv) check("trap_epc", trap_epc, exp_epc);
        if (id_valid) begin
            check("id_pc", id_pc, exp_pc);
            check("id_instr", id_instr, word_at(exp_pc[30:0]));
        end

        f_exc  = !rv && ex && id_valid;
        f_irq  = !rv && !f_exc && iq && id_valid && !stl && !exp_pc[31];
        exp_tv = f_exc || f_irq;
        if (f_exc)      exp_epc = next_pc(exp_pc);
        else if (f_irq) exp_epc = exp_pc;
        if (id_valid && !stl) begin
            exp_pc = next_pc(exp_pc);
            delivered++;
        end
        if (rv) begin
            tgt    = {rpc[31] & mode, rpc[30:0]};
            exp_pc = tgt;
            mode   = tgt[31];
        end else if (f_exc) begin
            exp_pc = XADR_VEC;  mode = 1'b1;
        end else if (f_irq) begin
            exp_pc = ILLOP_VEC; mode = 1'b1;
        end
        if (rv || f_exc || f_irq) check("req_on_flush", 32'(imem_req), 32'd0);

        if (imem_valid) mem_busy = 1'b0;
        if (imem_req) begin
            check("one_outstanding", 32'(mem_busy), 32'd0);
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        imem_valid = 1'b0; stall = 1'b0; redirect_valid = 1'b0; exc = 1'b0; irq = 1'b0;
        mem_busy = 1'b0;
        #2;
        check("rst_async_idv", 32'(id_valid), 32'd0);
        check("rst_async_req", 32'(imem_req), 32'd0);
        check("rst_async_tv", 32'(trap_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_instr", id_instr, 32'd0);
        check("rst_idpc", id_pc, 32'd0);
        check("rst_epc", trap_epc, 32'd0);
        exp_pc = RESET_VEC; mode = 1'b1; exp_tv = 1'b0;
        reset = 1'b1;
    endtask

    task automatic seq_check();
        for (int k = 1; k <= 8; k++) begin
            tick(0, 0, '0, 0, 0);
            check("seq_req", 32'(s_req), 32'(k >= 2));
            if (k >= 2) check("seq_addr", 32'(s_addr), 32'((k - 2) * 4));
            check("seq_idv", 32'(s_idv), 32'(k >= 4));
            if (k >= 4) check("seq_idpc", s_idpc, RESET_VEC + 32'((k - 4) * 4));
        end
    endtask

    task automatic await_req(input string tag, input logic [31:0] exp);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick(0, 0, '0, 0, 0);
            if (s_req) begin
                got = 1'b1;
                check(tag, 32'(s_addr), exp);
            end
        end
        check({tag, "_seen"}, 32'(got), 32'd1);
    endtask

    task automatic await_id(input string tag, input logic [31:0] exp);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick(0, 0, '0, 0, 0);
            if (s_idv) begin
                got = 1'b1;
                check(tag, s_idpc, exp);
            end
        end
        check({tag, "_seen"}, 32'(got), 32'd1);
    endtask

    // leaves the bench just before the edge where id_pc == pc is in decode
    task automatic await_pc(input string tag, input logic [31:0] pc);
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (id_valid && id_pc == pc) begin
                got = 1'b1;
                break;
            end
            tick(0, 0, '0, 0, 0);
        end
        check(tag, 32'(got), 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        bit          stl;
        bit          rv;
        logic [31:0] rpc;

        @(posedge clk);
        #1;
        do_reset();
        seq_check();

        // decode stall: hold, skid captures one word, no fetch
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, '0, 0, 0);
            if (i == 0) held = s_idpc;
            check("stall_noreq", 32'(s_req), 32'd0);
            check("stall_hold", s_idpc, held);
        end
        tick(0, 0, '0, 0, 0);
        check("drain_noreq", 32'(s_req), 32'd0);
        repeat (5) tick(0, 0, '0, 0, 0);

        // redirect with a response still in flight
        lat_min = 3; lat_max = 3;
        repeat (4) tick(0, 0, '0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            if (mem_busy && mem_cnt > 0) break;
            tick(0, 0, '0, 0, 0);
        end
        check("redir_in_wait", 32'(mem_busy && mem_cnt > 0), 32'd1);
        tick(0, 1, 32'h0000_0100, 0, 0);
        await_req("redir_addr", 32'h0000_0100);
        await_id("redir_idpc", 32'h0000_0100);
        tick(0, 1, 32'h8000_0040, 0, 0);
        await_req("user_redir_addr", 32'h0000_0040);
        await_id("user_redir_idpc", 32'h0000_0040);

        // exception wins over interrupt
        tick(0, 1, 32'h0000_0020, 0, 0);
        await_pc("exc_at_20", 32'h0000_0020);
        tick(0, 0, '0, 1, 1);
        tick(0, 0, '0, 0, 0);
        check("exc_tv", 32'(s_tv), 32'd1);
        check("exc_epc", s_epc, 32'h0000_0024);
        tick(0, 0, '0, 0, 0);
        check("exc_pulse", 32'(s_tv), 32'd0);
        await_id("exc_vec", XADR_VEC);

        // interrupt ignored in kernel mode, taken in user mode
        tick(0, 1, 32'h8000_0010, 0, 0);
        await_pc("irq_at_k10", 32'h8000_0010);
        tick(0, 0, '0, 0, 1);
        tick(0, 0, '0, 0, 0);
        check("irq_kmask", 32'(s_tv), 32'd0);
        tick(0, 1, 32'h0000_0010, 0, 0);
        await_pc("irq_at_u10", 32'h0000_0010);
        tick(0, 0, '0, 0, 1);
        tick(0, 0, '0, 0, 0);
        check("irq_tv", 32'(s_tv), 32'd1);
        check("irq_epc", s_epc, 32'h0000_0010);
        await_id("irq_vec", ILLOP_VEC);

        // PC wrap keeps the supervisor bit
        tick(0, 1, 32'hFFFF_FFFC, 0, 0);
        await_req("wrap_addr0", 32'h7FFF_FFFC);
        await_req("wrap_addr1", 32'h0000_0000);
        await_pc("wrap_pc", 32'h8000_0000);

        // random traffic
        lat_min = 1; lat_max = 3;
        delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            stl = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = {1'($urandom_range(0, 1)), 23'd0, 6'($urandom_range(0, 63)), 2'b00};
            tick(stl, rv, rpc, $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0);
        end
        check("progress", 32'(delivered > 300), 32'd1);

        // reset mid-stream, then restart cleanly
        lat_min = 1; lat_max = 1;
        do_reset();
        seq_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
